// File: rtl/alu_arbiter_if.sv
// Requester/consumer bundle for alu_arbiter: NUM_REQ packed request lanes plus one response lane.
// The arbiter binds the slave modport; requesters and the result consumer sit behind master.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [2*NUM_REQ-1:0]      req_sel;
    logic [DATA_W*NUM_REQ-1:0] req_a;
    logic [DATA_W*NUM_REQ-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;

    modport slave (
        input  req_valid, req_sel, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_sel, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered logic ALU (AND/OR/XOR/NOT) among NUM_REQ requesters.
// Latency: accept edge to rsp_valid is 2 cycles; one transaction in flight, accepts >= 3 cycles apart.
// Backpressure: rsp_ready low parks the result in RESP with all req_ready low. ALU_ARB_OPCNT_EN adds op_count.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus,
    output logic         busy
`ifdef ALU_ARB_OPCNT_EN
    ,
    output logic [31:0]  op_count
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    generate
        if (NUM_REQ < 2 || NUM_REQ > (2 ** ID_W)) begin : g_bad_cfg
            $error("alu_arbiter: NUM_REQ must be in 2..2**ID_W");
        end
    endgenerate

    logic [1:0]         state;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    op_id;
    logic [1:0]         op_sel;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;

    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [DATA_W-1:0]  rsp_data_q;

    logic               gnt_found;
    logic [ID_W-1:0]    gnt_idx;
    logic [1:0]         gnt_sel;
    logic [DATA_W-1:0]  gnt_a;
    logic [DATA_W-1:0]  gnt_b;
    logic [NUM_REQ-1:0] ready_vec;
    logic [DATA_W-1:0]  alu_res;

    // Two passes give rotating priority: indices above last_grant first, then wrap to the rest.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_sel   = '0;
        gnt_a     = '0;
        gnt_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && bus.req_valid[i] && (i > int'(last_grant))) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(i);
                gnt_sel   = bus.req_sel[2*i +: 2];
                gnt_a     = bus.req_a[DATA_W*i +: DATA_W];
                gnt_b     = bus.req_b[DATA_W*i +: DATA_W];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && bus.req_valid[i] && (i <= int'(last_grant))) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(i);
                gnt_sel   = bus.req_sel[2*i +: 2];
                gnt_a     = bus.req_a[DATA_W*i +: DATA_W];
                gnt_b     = bus.req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    // Ready is masked by rst so the accept strobe is quiet while reset is held.
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst && (state == IDLE) && gnt_found && (gnt_idx == ID_W'(i)))
                ready_vec[i] = 1'b1;
        end
    end

    always_comb begin
        alu_res = '0;
        case (op_sel)
            2'b00:   alu_res = op_a & op_b;
            2'b01:   alu_res = op_a | op_b;
            2'b10:   alu_res = op_a ^ op_b;
            default: alu_res = ~op_a;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= ID_W'(NUM_REQ - 1);
            op_id       <= '0;
            op_sel      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        op_id      <= gnt_idx;
                        op_sel     <= gnt_sel;
                        op_a       <= gnt_a;
                        op_b       <= gnt_b;
                        last_grant <= gnt_idx;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_res;
                    rsp_id_q    <= op_id;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_OPCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            op_count <= '0;
        else if ((state == RESP) && bus.rsp_ready)
            op_count <= op_count + 32'd1;
    end
`endif

    assign bus.req_ready = ready_vec;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state == EXEC) || (state == RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single-requester ops plus
// hand-written round-robin, backpressure, wrap-around and mid-operation reset sequences.
module tb_alu_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int DATA_W  = 32;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef ALU_ARB_OPCNT_EN
    logic [31:0] op_count;
`endif

    alu_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

    alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
`ifdef ALU_ARB_OPCNT_EN
        ,
        .op_count (op_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [1:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   exp_ops = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_cnt(input string name);
`ifdef ALU_ARB_OPCNT_EN
        chk(name, op_count, exp_ops);
`else
        if (name.len() == 0) $display("empty count tag");
`endif
    endtask

    task automatic set_req(input int i, input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
        bus.req_sel[2*i +: 2]          = sel;
        bus.req_a[DATA_W*i +: DATA_W]  = a;
        bus.req_b[DATA_W*i +: DATA_W]  = b;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_sel   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.rsp_valid", bus.rsp_valid, 0);
        chk("rst.rsp_id",    bus.rsp_id,    0);
        chk("rst.rsp_data",  bus.rsp_data,  0);
        chk("rst.busy",      busy,          0);
        chk("rst.req_ready", bus.req_ready, 0);
        exp_ops = 0;
        chk_cnt("rst.op_count");
        rst = 1'b0;
    endtask

    // One isolated transaction with rsp_ready held high.
    task automatic run_single(input vec_t v, input string tag);
        logic [3:0] onehot;
        onehot = 4'b0001 << v.id;
        @(negedge clk);
        set_req(int'(v.id), v.sel, v.a, v.b);
        bus.req_valid       = '0;
        bus.req_valid[v.id] = 1'b1;
        #1;
        chk($sformatf("%s.accept_ready", tag), bus.req_ready, onehot);
        @(negedge clk);
        bus.req_valid = '0;
        chk($sformatf("%s.exec_busy", tag),  busy,          1);
        chk($sformatf("%s.exec_valid", tag), bus.rsp_valid, 0);
        chk($sformatf("%s.exec_ready", tag), bus.req_ready, 0);
        @(negedge clk);
        chk($sformatf("%s.rsp_valid", tag), bus.rsp_valid, 1);
        chk($sformatf("%s.rsp_id", tag),    bus.rsp_id,    v.id);
        chk($sformatf("%s.rsp_data", tag),  bus.rsp_data,  v.exp);
        @(negedge clk);
        exp_ops++;
        chk($sformatf("%s.done_valid", tag), bus.rsp_valid, 0);
        chk($sformatf("%s.done_busy", tag),  busy,          0);
        chk_cnt($sformatf("%s.op_count", tag));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e;
        bit          saw_rsp;
        rst = 1'b1;

        vecs[0] = '{id: 2'd1, sel: 2'b00, a: 32'hF0F0F0F0, b: 32'hFF00FF00, exp: 32'hF000F000};
        vecs[1] = '{id: 2'd0, sel: 2'b11, a: 32'h12345678, b: 32'hDEADBEEF, exp: 32'hEDCBA987};
        vecs[2] = '{id: 2'd2, sel: 2'b01, a: 32'h0000FFFF, b: 32'hFFFF0000, exp: 32'hFFFFFFFF};
        vecs[3] = '{id: 2'd3, sel: 2'b10, a: 32'hAAAA5555, b: 32'h0F0F0F0F, exp: 32'hA5A55A5A};
        vecs[4] = '{id: 2'd0, sel: 2'b00, a: 32'hFFFFFFFF, b: 32'h12345678, exp: 32'h12345678};
        vecs[5] = '{id: 2'd2, sel: 2'b11, a: 32'h00000000, b: 32'hFFFFFFFF, exp: 32'hFFFFFFFF};
        vecs[6] = '{id: 2'd1, sel: 2'b01, a: 32'h80000001, b: 32'h00000000, exp: 32'h80000001};
        vecs[7] = '{id: 2'd3, sel: 2'b10, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, exp: 32'h00000000};

        do_reset();
        for (int v = 0; v < 8; v++)
            run_single(vecs[v], $sformatf("vec%0d", v));

        // All four held valid: grants rotate 0,1,2,3,0 three cycles apart.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 2'b10, 32'(i), 32'hFFFFFFFF);
        @(negedge clk);
        bus.req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr%0d.ready", k), bus.req_ready, 4'b0001 << (k % 4));
            @(negedge clk);
            if (k == 4) bus.req_valid = '0;
            chk($sformatf("rr%0d.busy", k), busy, 1);
            @(negedge clk);
            e = ~32'(k % 4);
            chk($sformatf("rr%0d.rsp_valid", k), bus.rsp_valid, 1);
            chk($sformatf("rr%0d.rsp_id", k),    bus.rsp_id,    k % 4);
            chk($sformatf("rr%0d.rsp_data", k),  bus.rsp_data,  e);
            @(negedge clk);
            exp_ops++;
        end
        chk("rr.idle_busy", busy, 0);
        chk_cnt("rr.op_count");

        // Backpressure in RESP with requester 0 arriving while busy.
        do_reset();
        set_req(2, 2'b00, 32'h0F0FFFFF, 32'h3C3C00FF);
        set_req(0, 2'b01, 32'h00000001, 32'h00000002);
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 4'b0100;
        #1;
        chk("bp.accept2", bus.req_ready, 4'b0100);
        @(negedge clk);
        bus.req_valid = 4'b0001;
        #1;
        chk("bp.exec_ready", bus.req_ready, 0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d.rsp_valid", c), bus.rsp_valid, 1);
            chk($sformatf("bp%0d.rsp_data", c),  bus.rsp_data,  32'h0C0C00FF);
            chk($sformatf("bp%0d.rsp_id", c),    bus.rsp_id,    2);
            chk($sformatf("bp%0d.req_ready", c), bus.req_ready, 0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        exp_ops++;
        chk("bp.accept0",    bus.req_ready, 4'b0001);
        chk("bp.valid_low",  bus.rsp_valid, 0);
        chk("bp.data_kept",  bus.rsp_data,  32'h0C0C00FF);
        chk_cnt("bp.op_count");
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        chk("bp.rsp0_id",   bus.rsp_id,   0);
        chk("bp.rsp0_data", bus.rsp_data, 32'h00000003);
        @(negedge clk);
        exp_ops++;

        // Wrap-around: last grant 2, requesters 0 and 3 valid -> 3 then 0.
        do_reset();
        run_single(vecs[2], "wrap_seed");
        set_req(0, 2'b10, 32'h00000000, 32'hFFFFFFFF);
        set_req(3, 2'b10, 32'h00000003, 32'hFFFFFFFF);
        @(negedge clk);
        bus.req_valid = 4'b1001;
        #1;
        chk("wrap.first_ready", bus.req_ready, 4'b1000);
        @(negedge clk);
        @(negedge clk);
        chk("wrap.first_id",   bus.rsp_id,   3);
        chk("wrap.first_data", bus.rsp_data, 32'hFFFFFFFC);
        @(negedge clk);
        #1;
        exp_ops++;
        chk("wrap.second_ready", bus.req_ready, 4'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        chk("wrap.second_id",   bus.rsp_id,   0);
        chk("wrap.second_data", bus.rsp_data, 32'hFFFFFFFF);
        @(negedge clk);
        exp_ops++;
        chk_cnt("wrap.op_count");

        // Reset during EXEC: rsp_data was nonzero, must clear at once; no response follows.
        set_req(3, 2'b11, 32'h00000000, 32'h00000000);
        @(negedge clk);
        bus.req_valid = 4'b1000;
        #1;
        chk("rexec.accept3", bus.req_ready, 4'b1000);
        @(negedge clk);
        bus.req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        exp_ops = 0;
        chk("rexec.rsp_valid", bus.rsp_valid, 0);
        chk("rexec.busy",      busy,          0);
        chk("rexec.rsp_data",  bus.rsp_data,  0);
        chk("rexec.rsp_id",    bus.rsp_id,    0);
        chk_cnt("rexec.op_count");
        @(negedge clk);
        rst     = 1'b0;
        saw_rsp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) saw_rsp = 1'b1;
        end
        chk("rexec.no_response", saw_rsp, 0);

        // Reset during RESP with 0,1,3 pending; after release requester 0 wins again.
        set_req(0, 2'b10, 32'h00000000, 32'hFFFFFFFF);
        set_req(1, 2'b00, 32'h00000000, 32'h00000000);
        bus.req_valid = 4'b1011;
        #1;
        chk("rresp.accept0", bus.req_ready, 4'b0001);
        @(negedge clk);
        @(negedge clk);
        chk("rresp.rsp_valid_before", bus.rsp_valid, 1);
        chk("rresp.rsp_data_before",  bus.rsp_data,  32'hFFFFFFFF);
        bus.rsp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rresp.rsp_valid", bus.rsp_valid, 0);
        chk("rresp.busy",      busy,          0);
        chk("rresp.rsp_data",  bus.rsp_data,  0);
        chk("rresp.req_ready", bus.req_ready, 0);
        chk_cnt("rresp.op_count");
        @(negedge clk);
        rst           = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        chk("rresp.prio0", bus.req_ready, 4'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        chk("rresp.rsp_id",   bus.rsp_id,   0);
        chk("rresp.rsp_data", bus.rsp_data, 32'hFFFFFFFF);
        @(negedge clk);
        exp_ops++;
        chk("rresp.idle_busy", busy, 0);
        chk_cnt("rresp.op_count");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 32-bit logic ALU (AND/OR/XOR/NOT) between NUM_REQ requesters.
- Round-robin arbitration; valid/ready handshake on every requester port and on the single response port.
- Contains a registered ALU stage with one-cycle compute latency, matching the existing ALU datapath timing.
- Sits between requesting units (sequencers, DMA-style clients) and the ALU result consumer.

Parameters:
- NUM_REQ, 4, number of requesters (2..4).
- ID_W, 2, width of the requester ID; NUM_REQ <= 2**ID_W is required.
- DATA_W, 32, operand and result width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_sel  input  2*NUM_REQ  opcode, requester i at bits [2i+1:2i]. 00 = a&b, 01 = a|b, 10 = a^b, 11 = ~a.
- req_a  input  DATA_W*NUM_REQ  operand a, requester i at bits [DATA_W*i +: DATA_W].
- req_b  input  DATA_W*NUM_REQ  operand b, same packing as req_a.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_data  output  DATA_W  ALU result.
- busy  output  1  high in EXEC or RESP.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, req_ready=0. Internal operand and opcode registers = 0. Round-robin pointer last_grant = NUM_REQ-1, so requester 0 wins first.
- IDLE:
  - Grant the first requester with req_valid=1, searching from last_grant+1 and wrapping modulo NUM_REQ.
  - req_ready for the granted requester is driven combinationally in the same cycle. This is the accept cycle.
  - On the accept edge: capture that requester's sel, a, b and index; set last_grant = index; go to EXEC.
  - No valid requester: stay in IDLE, all req_ready=0.
- EXEC (exactly one cycle):
  - rsp_data <= result of the captured op; rsp_id <= captured index; go to RESP.
  - Op 11 ignores b.
  - Results are bitwise and DATA_W wide; there is no carry or flag.
- RESP:
  - rsp_valid=1. rsp_data and rsp_id hold stable until rsp_ready=1.
  - On the handshake edge: rsp_valid <= 0 and go to IDLE.
  - rsp_data keeps its last value after the handshake.
- Latency: accept edge to rsp_valid is 2 cycles. Minimum spacing between accepts is 3 cycles with no backpressure.
- req_ready is 0 in EXEC and RESP. Requests that arrive then wait; requesters must hold valid and operands stable until accepted.
- A requester's req_valid must not depend on its req_ready.
- Simultaneous valids: exactly one grant per accept. Every continuously-valid requester is granted within NUM_REQ accepts.
- A requester dropping valid before being accepted is legal; nothing is recorded for it.
- rsp_ready held high while not in RESP has no effect.
- Reset asserted mid-operation (EXEC or RESP): the transaction is discarded with no response, and all outputs and the pointer return to reset values immediately (asynchronous).

Optional Feature:
- Macro: ALU_ARB_OPCNT_EN.
- Defined:
  - Adds output port op_count, 32 bits.
  - Reset value 0.
  - Increments by 1 on each response handshake (RESP with rsp_ready=1).
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- After reset, requester 1 only: valid with sel=00, a=0xF0F0F0F0, b=0xFF00FF00, rsp_ready=1 -> req_ready[1] in the same cycle; 2 cycles later rsp_valid=1, rsp_id=1, rsp_data=0xF000F000; then back to IDLE.
- All 4 requesters held valid with rsp_ready=1 -> accepts in order 0,1,2,3,0, spaced 3 cycles apart. Requester i uses sel=10, a=i, b=0xFFFFFFFF, so rsp_data=~i.
- Backpressure: rsp_ready=0 for 5 cycles while in RESP -> rsp_valid, rsp_data and rsp_id stable; req_ready all 0; a pending requester is accepted the cycle after the handshake edge.
- Op 11 with a=0x12345678, b=0xDEADBEEF -> rsp_data=0xEDCBA987. Op 01 with a=0x0000FFFF, b=0xFFFF0000 -> rsp_data=0xFFFFFFFF.
- Wrap-around: last grant was 2, requesters 0 and 3 valid -> grant 3, then 0.
- Assert rst during EXEC and again during RESP -> rsp_valid=0 and busy=0 immediately; no response emitted; after release, requester 0 has priority. With ALU_ARB_OPCNT_EN, op_count=0 after reset and counts exactly the completed handshakes.
